// File: rtl/image_stream_framer.sv
// -----------------------------------------------------------------------------
// image_stream_framer
//
// Frames the 80-bit packed pixel stream from the image output interface into
// AXI4-Stream beats. Each frame gets a header beat (tuser=1) and every
// line ends with tlast. Beats are buffered in a first-word-fall-through FIFO
// whose head is presented through a register. Frame, drop and overflow
// status are reported for the status registers.
//
// Optional feature: define FRAMER_TRAILER_EN to append a one-beat trailer
// (tuser=0, tlast=1) carrying pixel-beat count and status after each
// completed frame.
//
// Ports
//   sys_clk, sys_rst_n      : clock, synchronous active-low reset
//   new_frame               : one-cycle frame start; samples imageRow/imageCol
//   imageRow, imageCol      : lines per frame, pixels per line (8 px per beat)
//   imageData, imageDataVld : packed pixel beat and qualifier (no backpressure)
//   clear_status            : clears ovfl, truncated and dropCnt
//   m_axis_*                : AXI4-Stream master (tuser = SOF, tlast = EOL)
//   frameCnt                : frames started (wraps)
//   dropCnt                 : beats arriving outside a frame (saturating)
//   ovfl                    : sticky, write attempted while FIFO full
//   truncated               : sticky, frame aborted
//   fifo_level              : FIFO occupancy, including the presented head
// -----------------------------------------------------------------------------
module image_stream_framer #(
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [15:0] HDR_SYNC   = 16'hA5C3
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          new_frame,
    input  logic [15:0]                   imageRow,
    input  logic [15:0]                   imageCol,
    input  logic [79:0]                   imageData,
    input  logic                          imageDataVld,
    input  logic                          clear_status,
    output logic [79:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [31:0]                   frameCnt,
    output logic [15:0]                   dropCnt,
    output logic                          ovfl,
    output logic                          truncated,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DATA_W  = 80;
    localparam int ENTRY_W = DATA_W + 2;
    localparam int AW      = $clog2(FIFO_DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [16:0] nonzero17(input logic [16:0] v);
        return (v == 17'd0) ? 17'd1 : v;
    endfunction

    function automatic logic [15:0] nonzero16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

`ifdef FRAMER_TRAILER_EN
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_TRAILER} state_t;
    logic [31:0] pixel_beats;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE} state_t;
`endif

    state_t             state;
    logic [16:0]        beats_per_line;
    logic [15:0]        line_total;
    logic [16:0]        beat_cnt;
    logic [15:0]        line_cnt;

    logic               wr_req_p0;
    logic [ENTRY_W-1:0] wr_entry_p0;
    logic [ENTRY_W-1:0] hdr_entry_p0;
    logic               start_p0;
    logic               abort_p0;
    logic               drop_p0;
    logic               pix_p0;
    logic               last_beat_p0;
    logic               last_line_p0;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               pop;
    logic               wr_ok;
    logic               ovfl_evt;

    logic               vld_p1;
    logic [ENTRY_W-1:0] out_p1;

    // ---- stage p0: decode the input cycle into at most one FIFO write ----
    assign hdr_entry_p0 = {1'b1, 1'b0, frameCnt, imageRow, imageCol, HDR_SYNC};
    assign last_beat_p0 = (beat_cnt == beats_per_line - 17'd1);
    assign last_line_p0 = (line_cnt == line_total - 16'd1);

    always_comb begin
        wr_req_p0   = 1'b0;
        wr_entry_p0 = '0;
        start_p0    = 1'b0;
        abort_p0    = 1'b0;
        drop_p0     = 1'b0;
        pix_p0      = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_frame) begin
                    wr_req_p0   = 1'b1;
                    wr_entry_p0 = hdr_entry_p0;
                    start_p0    = 1'b1;
                end
                drop_p0 = imageDataVld;
            end
            S_ACTIVE: begin
                if (new_frame) begin
                    wr_req_p0   = 1'b1;
                    wr_entry_p0 = hdr_entry_p0;
                    start_p0    = 1'b1;
                    abort_p0    = 1'b1;
                    drop_p0     = imageDataVld;
                end else if (imageDataVld) begin
                    wr_req_p0   = 1'b1;
                    wr_entry_p0 = {1'b0, last_beat_p0, imageData};
                    pix_p0      = 1'b1;
                end
            end
`ifdef FRAMER_TRAILER_EN
            S_TRAILER: begin
                // A new_frame here only marks truncation; its frame start is lost.
                wr_req_p0   = 1'b1;
                wr_entry_p0 = {1'b0, 1'b1, pixel_beats, dropCnt, 14'b0,
                               truncated, ovfl, 16'h5A3C};
                abort_p0    = new_frame;
                drop_p0     = imageDataVld;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state          <= S_IDLE;
            beats_per_line <= 17'd1;
            line_total     <= 16'd1;
            beat_cnt       <= '0;
            line_cnt       <= '0;
            frameCnt       <= '0;
            dropCnt        <= '0;
            ovfl           <= 1'b0;
            truncated      <= 1'b0;
`ifdef FRAMER_TRAILER_EN
            pixel_beats    <= '0;
`endif
        end else begin
            if (start_p0) begin
                state          <= S_ACTIVE;
                frameCnt       <= frameCnt + 32'd1;
                beats_per_line <= nonzero17(({1'b0, imageCol} + 17'd7) >> 3);
                line_total     <= nonzero16(imageRow);
                beat_cnt       <= '0;
                line_cnt       <= '0;
`ifdef FRAMER_TRAILER_EN
                pixel_beats    <= '0;
`endif
            end else if (pix_p0) begin
                // Counters advance even when the FIFO discards the write,
                // keeping tlast aligned with the incoming lines.
                if (last_beat_p0) begin
                    beat_cnt <= '0;
                    line_cnt <= line_cnt + 16'd1;
                    if (last_line_p0) begin
`ifdef FRAMER_TRAILER_EN
                        state <= S_TRAILER;
`else
                        state <= S_IDLE;
`endif
                    end
                end else begin
                    beat_cnt <= beat_cnt + 17'd1;
                end
`ifdef FRAMER_TRAILER_EN
                pixel_beats <= pixel_beats + 32'd1;
`endif
            end
`ifdef FRAMER_TRAILER_EN
            else if (state == S_TRAILER) begin
                state <= S_IDLE;
            end
`endif

            // Set events take priority over clear_status.
            if (drop_p0)
                dropCnt <= sat_inc16(clear_status ? 16'd0 : dropCnt);
            else if (clear_status)
                dropCnt <= '0;

            if (ovfl_evt)
                ovfl <= 1'b1;
            else if (clear_status)
                ovfl <= 1'b0;

            if (abort_p0)
                truncated <= 1'b1;
            else if (clear_status)
                truncated <= 1'b0;
        end
    end

    // ---- FIFO storage: the head entry stays in memory until transferred ----
    assign pop      = vld_p1 & m_axis_tready;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_ok    = wr_req_p0 & (~full | pop);
    assign ovfl_evt = wr_req_p0 & full & ~pop;

    always_ff @(posedge sys_clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_entry_p0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
        end
    end

    assign fifo_level = count;

    // ---- stage p1: registered copy of the FIFO head ----
    // Only entries already in memory are eligible, which gives the two-cycle
    // write-to-valid latency from an empty FIFO.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
        end else if (!vld_p1) begin
            if (count != '0) begin
                vld_p1 <= 1'b1;
                out_p1 <= mem[rd_ptr];
            end
        end else if (pop) begin
            vld_p1 <= (count > (AW+1)'(1));
            if (count > (AW+1)'(1))
                out_p1 <= mem[rd_ptr + AW'(1)];
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = out_p1[DATA_W-1:0];
    assign m_axis_tlast  = out_p1[DATA_W];
    assign m_axis_tuser  = out_p1[DATA_W+1];

endmodule

// File: tb/tb_image_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_image_stream_framer
//
// Self-checking bench for image_stream_framer (FIFO_DEPTH = 16). A frame-level
// reference model turns each input cycle into the expected output beats,
// which are compared against beats collected from the AXI4-Stream port.
// Honours FRAMER_TRAILER_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_image_stream_framer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FRAMER_TRAILER_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    typedef logic [81:0] ent_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          new_frame = 1'b0;
    logic [15:0]   imageRow = '0;
    logic [15:0]   imageCol = '0;
    logic [79:0]   imageData = '0;
    logic          imageDataVld = 1'b0;
    logic          clear_status = 1'b0;
    logic [79:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic [31:0]   frameCnt;
    logic [15:0]   dropCnt;
    logic          ovfl;
    logic          truncated;
    logic [LW-1:0] fifo_level;

    int checks = 0;
    int errors = 0;

    ent_t exp_q[$];
    ent_t got_q[$];

    // reference model state
    bit          m_in_frame;
    bit          m_tr_pending;
    bit          m_ovfl;
    bit          m_trunc;
    int          m_pix;
    int          m_bpl;
    int          m_lines;
    logic [31:0] m_frames;
    logic [15:0] m_drop;

    image_stream_framer #(.FIFO_DEPTH(DEPTH), .HDR_SYNC(16'hA5C3)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .new_frame    (new_frame),
        .imageRow     (imageRow),
        .imageCol     (imageCol),
        .imageData    (imageData),
        .imageDataVld (imageDataVld),
        .clear_status (clear_status),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .frameCnt     (frameCnt),
        .dropCnt      (dropCnt),
        .ovfl         (ovfl),
        .truncated    (truncated),
        .fifo_level   (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    // Collect transfers half a cycle before the edge that completes them.
    always @(negedge sys_clk) begin
        if (sys_rst_n && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] rnd80();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        m_in_frame   = 0;
        m_tr_pending = 0;
        m_ovfl       = 0;
        m_trunc      = 0;
        m_pix        = 0;
        m_bpl        = 1;
        m_lines      = 1;
        m_frames     = '0;
        m_drop       = '0;
    endtask

    // Returns 1 when the write finds the FIFO full (no reads in flight).
    function automatic bit model_write(input ent_t e);
        if (exp_q.size() - got_q.size() >= DEPTH)
            return 1'b1;
        exp_q.push_back(e);
        return 1'b0;
    endfunction

    task automatic model_step(input bit nf, input logic [15:0] row, input logic [15:0] col,
                              input bit vld, input logic [79:0] d, input bit clr);
        bit set_ovfl  = 0;
        bit set_trunc = 0;
        bit drop      = 0;
        if (m_tr_pending) begin
            set_ovfl = model_write({1'b0, 1'b1, 32'(m_pix), m_drop, 14'b0, m_trunc, m_ovfl, 16'h5A3C});
            drop = vld;
            set_trunc = nf;
            m_tr_pending = 0;
        end else if (nf) begin
            set_ovfl = model_write({2'b10, m_frames, row, col, 16'hA5C3});
            set_trunc = m_in_frame;
            drop = vld;
            m_frames = m_frames + 32'd1;
            m_in_frame = 1;
            m_pix = 0;
            m_bpl = (int'(col) + 7) / 8;
            if (m_bpl == 0) m_bpl = 1;
            m_lines = (row == 16'd0) ? 1 : int'(row);
        end else if (vld) begin
            if (!m_in_frame) begin
                drop = 1;
            end else begin
                set_ovfl = model_write({1'b0, ((m_pix + 1) % m_bpl) == 0, d});
                m_pix++;
                if (m_pix == m_bpl * m_lines) begin
                    m_in_frame = 0;
                    m_tr_pending = (TR == 1);
                end
            end
        end
        if (clr) begin
            m_drop = '0;
            m_trunc = 0;
            m_ovfl = 0;
        end
        if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (set_trunc) m_trunc = 1;
        if (set_ovfl) m_ovfl = 1;
    endtask

    task automatic cycle(input bit nf, input logic [15:0] row, input logic [15:0] col,
                         input bit vld, input logic [79:0] d, input bit clr);
        new_frame = nf;
        imageRow = row;
        imageCol = col;
        imageDataVld = vld;
        imageData = d;
        clear_status = clr;
        @(posedge sys_clk);
        model_step(nf, row, col, vld, d, clr);
        #1;
        new_frame = 0;
        imageDataVld = 0;
        clear_status = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, imageRow, imageCol, 0, '0, 0);
    endtask

    task automatic beat();
        cycle(0, imageRow, imageCol, 1, rnd80(), 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        new_frame = 0;
        imageDataVld = 0;
        clear_status = 0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1;
        model_reset();
    endtask

    task automatic drain(output bit timed_out);
        int n = 0;
        m_axis_tready = 1;
        while (got_q.size() < exp_q.size() && n < 500) begin
            idle(1);
            n++;
        end
        timed_out = (got_q.size() < exp_q.size());
        idle(3);
    endtask

    task automatic test_reset();
        sys_rst_n = 0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: valid/user/last=%b required 000", {m_axis_tvalid, m_axis_tuser, m_axis_tlast});
        end
        checks++;
        if (m_axis_tdata !== 80'd0) begin
            errors++;
            $display("FAIL reset_tdata: got %h required 0", m_axis_tdata);
        end
        checks++;
        if ({frameCnt, dropCnt, ovfl, truncated} !== 50'd0) begin
            errors++;
            $display("FAIL reset_status: frameCnt=%0d dropCnt=%0d ovfl=%b truncated=%b required all 0",
                     frameCnt, dropCnt, ovfl, truncated);
        end
        checks++;
        if (fifo_level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d required 0", fifo_level);
        end
        sys_rst_n = 1;
        model_reset();
    endtask

    task automatic test_nominal();
        bit to;
        logic [15:0] tl;
        do_reset();
        m_axis_tready = 1;
        cycle(1, 16'd4, 16'd32, 0, '0, 0);
        checks++;
        if (m_axis_tvalid !== 1'b0 || fifo_level !== LW'(1)) begin
            errors++;
            $display("FAIL latency_n1: tvalid=%b level=%0d required 0 and 1", m_axis_tvalid, fifo_level);
        end
        checks++;
        if (frameCnt !== 32'd1) begin
            errors++;
            $display("FAIL nominal_framecnt_early: got %0d required 1", frameCnt);
        end
        beat();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1) begin
            errors++;
            $display("FAIL latency_n2: tvalid=%b tuser=%b required 1 1", m_axis_tvalid, m_axis_tuser);
        end
        for (int i = 1; i < 16; i++) begin
            idle($urandom_range(0, 1));
            beat();
        end
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size() || got_q.size() != 17 + TR) begin
            errors++;
            $display("FAIL nominal_count: got %0d beats, model %0d, required %0d", got_q.size(), exp_q.size(), 17 + TR);
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL nominal_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        if (got_q.size() >= 17) begin
            checks++;
            if (got_q[0][81] !== 1'b1 || got_q[0][15:0] !== 16'hA5C3) begin
                errors++;
                $display("FAIL nominal_header: tuser=%b sync=%h required 1 a5c3", got_q[0][81], got_q[0][15:0]);
            end
            for (int i = 1; i <= 16; i++) tl[i-1] = got_q[i][80];
            checks++;
            if (tl !== 16'h8888) begin
                errors++;
                $display("FAIL nominal_tlast: pattern %b required 1000100010001000", tl);
            end
        end
        checks++;
        if (frameCnt !== 32'd1 || dropCnt !== 16'd0) begin
            errors++;
            $display("FAIL nominal_status: frameCnt=%0d dropCnt=%0d required 1 0", frameCnt, dropCnt);
        end
`ifdef FRAMER_TRAILER_EN
        if (got_q.size() >= 18) begin
            checks++;
            if (got_q[17][80] !== 1'b1 || got_q[17][15:0] !== 16'h5A3C || got_q[17][79:48] !== 32'd16) begin
                errors++;
                $display("FAIL trailer_beat: tlast=%b tag=%h pixelBeats=%0d required 1 5a3c 16",
                         got_q[17][80], got_q[17][15:0], got_q[17][79:48]);
            end
        end
`endif
    endtask

    task automatic test_ragged();
        bit to;
        logic [5:0] tl;
        int base;
        do_reset();
        m_axis_tready = 1;
        cycle(1, 16'd2, 16'd20, 0, '0, 0);
        repeat (6) beat();
        idle(2);
        cycle(1, 16'd2, 16'd0, 0, '0, 0);
        repeat (2) beat();
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size() || got_q.size() != 10 + 2 * TR) begin
            errors++;
            $display("FAIL ragged_count: got %0d beats, model %0d, required %0d", got_q.size(), exp_q.size(), 10 + 2 * TR);
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ragged_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        base = 7 + TR;
        if (got_q.size() >= base + 3) begin
            for (int i = 0; i < 6; i++) tl[i] = got_q[i + 1][80];
            checks++;
            if (tl !== 6'b100100) begin
                errors++;
                $display("FAIL ragged_tlast20: pattern %b required 100100", tl);
            end
            checks++;
            if (got_q[base + 1][80] !== 1'b1 || got_q[base + 2][80] !== 1'b1) begin
                errors++;
                $display("FAIL ragged_tlast0: tlast %b %b required 1 1", got_q[base + 1][80], got_q[base + 2][80]);
            end
        end
    endtask

    task automatic test_overflow();
        bit to;
        do_reset();
        m_axis_tready = 0;
        cycle(1, 16'd5, 16'd64, 0, '0, 0);
        repeat (40) beat();
        idle(2);
        checks++;
        if (ovfl !== 1'b1 || fifo_level !== LW'(16)) begin
            errors++;
            $display("FAIL ovfl_full: ovfl=%b level=%0d required 1 16", ovfl, fifo_level);
        end
        drain(to);
        checks++;
        if (to || got_q.size() != 16 || exp_q.size() != 16) begin
            errors++;
            $display("FAIL ovfl_count: got %0d beats, model %0d, required 16", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ovfl_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        cycle(0, imageRow, imageCol, 0, '0, 1);
        checks++;
        if (ovfl !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL ovfl_clear: ovfl=%b level=%0d required 0 0", ovfl, fifo_level);
        end
    endtask

    task automatic test_full_boundary();
        bit to;
        do_reset();
        m_axis_tready = 0;
        cycle(1, 16'd4, 16'd64, 0, '0, 0);
        repeat (15) beat();
        idle(2);
        checks++;
        if (fifo_level !== LW'(16) || ovfl !== 1'b0) begin
            errors++;
            $display("FAIL full_fill: level=%0d ovfl=%b required 16 0", fifo_level, ovfl);
        end
        m_axis_tready = 1;
        beat();
        checks++;
        if (fifo_level !== LW'(16) || ovfl !== 1'b0) begin
            errors++;
            $display("FAIL full_rw: level=%0d ovfl=%b required 16 0", fifo_level, ovfl);
        end
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size() || got_q.size() != 17) begin
            errors++;
            $display("FAIL full_count: got %0d beats, model %0d, required 17", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL full_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_abort_drops();
        bit to;
        do_reset();
        m_axis_tready = 1;
        repeat (3) beat();
        checks++;
        if (dropCnt !== 16'd3) begin
            errors++;
            $display("FAIL idle_drops: got %0d required 3", dropCnt);
        end
        cycle(1, 16'd2, 16'd64, 0, '0, 0);
        repeat (5) beat();
        cycle(1, 16'd2, 16'd64, 1, rnd80(), 0);
        checks++;
        if (truncated !== 1'b1 || frameCnt !== 32'd2 || dropCnt !== 16'd4) begin
            errors++;
            $display("FAIL abort_status: truncated=%b frameCnt=%0d dropCnt=%0d required 1 2 4",
                     truncated, frameCnt, dropCnt);
        end
        repeat (16) beat();
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size() || got_q.size() != 23 + TR) begin
            errors++;
            $display("FAIL abort_count: got %0d beats, model %0d, required %0d", got_q.size(), exp_q.size(), 23 + TR);
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        if (got_q.size() > 6) begin
            checks++;
            if (got_q[6][81] !== 1'b1 || got_q[6][79:48] !== 32'd1 || got_q[5][80] !== 1'b0) begin
                errors++;
                $display("FAIL abort_header: tuser=%b frame field=%0d partial tlast=%b required 1 1 0",
                         got_q[6][81], got_q[6][79:48], got_q[5][80]);
            end
        end
        cycle(0, imageRow, imageCol, 0, '0, 1);
        checks++;
        if (truncated !== 1'b0 || dropCnt !== 16'd0 || frameCnt !== 32'd2) begin
            errors++;
            $display("FAIL abort_clear: truncated=%b dropCnt=%0d frameCnt=%0d required 0 0 2",
                     truncated, dropCnt, frameCnt);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        m_axis_tready = 0;
        cycle(1, 16'd2, 16'd64, 0, '0, 0);
        repeat (10) beat();
        idle(1);
        checks++;
        if (fifo_level !== LW'(11) || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: level=%0d tvalid=%b required 11 1", fifo_level, m_axis_tvalid);
        end
        sys_rst_n = 0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1;
        model_reset();
        checks++;
        if (m_axis_tvalid !== 1'b0 || fifo_level !== '0 || frameCnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset: tvalid=%b level=%0d frameCnt=%0d required 0 0 0",
                     m_axis_tvalid, fifo_level, frameCnt);
        end
        m_axis_tready = 1;
        beat();
        idle(3);
        checks++;
        if (dropCnt !== 16'd1 || m_axis_tvalid !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_idle: dropCnt=%0d tvalid=%b beats=%0d required 1 0 0",
                     dropCnt, m_axis_tvalid, got_q.size());
        end
    endtask

    task automatic rnd_cycle(input bit nf, input logic [15:0] row, input logic [15:0] col, input bit vld);
        m_axis_tready = ($urandom_range(0, 3) != 0);
        if (!nf && vld && (exp_q.size() - got_q.size() >= 10))
            cycle(0, row, col, 0, '0, 0);
        else
            cycle(nf, row, col, vld, rnd80(), 0);
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [15:0] row;
        logic [15:0] col;
        int total;
        int send;
        int sent;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            row = 16'($urandom_range(0, 3));
            col = 16'($urandom_range(0, 40));
            total = ((int'(col) + 7) / 8 == 0 ? 1 : (int'(col) + 7) / 8) * (row == 0 ? 1 : int'(row));
            send = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total) : total;
            for (int s = $urandom_range(0, 2); s > 0; s--) rnd_cycle(0, row, col, 1);
            rnd_cycle(1, row, col, $urandom_range(0, 1) == 1);
            sent = 0;
            while (sent < send) begin
                if ($urandom_range(0, 2) == 0) begin
                    rnd_cycle(0, row, col, 0);
                end else begin
                    if (exp_q.size() - got_q.size() < 10) sent++;
                    rnd_cycle(0, row, col, 1);
                end
            end
        end
        drain(to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, model %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (frameCnt !== m_frames || dropCnt !== m_drop || truncated !== m_trunc || ovfl !== m_ovfl) begin
            errors++;
            $display("FAIL b2b_status: frameCnt=%0d dropCnt=%0d trunc=%b ovfl=%b required %0d %0d %b %b",
                     frameCnt, dropCnt, truncated, ovfl, m_frames, m_drop, m_trunc, m_ovfl);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_ragged();
        test_overflow();
        test_full_boundary();
        test_abort_drops();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
